// File: rtl/riscv_uart_pkg.sv
// Purpose: shared register map, STATUS bit positions and receiver FSM states for the UART RX block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_uart_pkg;

    // Oversampling factor: ticks per serial bit.
    localparam int OVS = 16;

    // Register offsets, decoded from addr[11:0].
    typedef enum logic [11:0] {
        A_STATUS = 12'h000,
        A_RXDATA = 12'h008
    } addr_e;

    // STATUS register bit positions.
    localparam int ST_NONEMPTY  = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 8;

    // Receiver states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    // Clocks per oversample tick, rounded down.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVS);
    endfunction

endpackage

// File: rtl/riscv_uart_rx_if.sv
// Purpose: APB-style register bus between the CPU (master) and the UART RX peripheral (slave).
// Latency: access acts in the cycle where sel && enable; rdata is combinational.
// Backpressure: none, the slave never stalls (no ready signal).
interface riscv_uart_rx_if #(
    parameter int XLEN = 32
);
    logic            sel;
    logic            enable;
    logic            write;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;

    modport master (
        output sel, enable, write, addr, wdata,
        input  rdata
    );

    modport slave (
        input  sel, enable, write, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/riscv_uart_rx_fifo.sv
// Purpose: synchronous FIFO holding received bytes. Ports: push_i/data_i in, pop_i/data_o out,
//          full_o/empty_o/count_o status. Latency: 1 clk push-to-visible; data_o shows head combinationally.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module riscv_uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the head slot; the write lands in that
    // same slot at the clock edge, after the head has already been read out.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/riscv_uart_rx.sv
// Purpose: UART 8N1 receiver with RX FIFO on an APB-style bus. Ports: clk, rstn, bus (slave: STATUS @0x000,
//          RXDATA @0x008), rxd serial in. Latency: 2 clk synchroniser; byte visible 1 clk after mid-stop sample.
// Backpressure: none on the line; a byte arriving to a full FIFO without a same-cycle pop is dropped and flags overrun.
module riscv_uart_rx
    import riscv_uart_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    riscv_uart_rx_if.slave    bus,
    input  logic              rxd
);

    localparam int DIV  = calc_div(CLK_FREQ, BAUD);
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCW  = $clog2(OVS);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Input synchroniser; rx_prev_q gives the falling-edge detector.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q && !rx_sync_q;

    // ------------------------------------------------------------------
    // Oversample tick: free-running divider, re-phased on start detection
    // so the mid-bit sample point tracks the incoming frame.
    // ------------------------------------------------------------------
    logic [DIVW-1:0] div_cnt_q;
    logic            tick;
    logic            tick_restart;

    assign tick = (div_cnt_q == DIVW'(DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q <= '0;
        end else if (tick_restart || tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_e      state_q;
    rx_state_e      state_d;
    logic [TCW-1:0] tick_cnt_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           mid_tick;
    logic           bit_tick;

    // Start bit is checked half a bit in; later bits one full bit apart.
    assign mid_tick = tick && (tick_cnt_q == TCW'(OVS / 2 - 1));
    assign bit_tick = tick && (tick_cnt_q == TCW'(OVS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (rx_fall)  state_d = START;
            START: if (mid_tick) state_d = rx_sync_q ? IDLE : DATA;
            DATA:  if (bit_tick && bit_cnt_q == 3'd7) state_d = STOP;
            STOP:  if (bit_tick) state_d = rx_sync_q ? IDLE : BREAK;
            BREAK: if (rx_sync_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic tcnt_clr;
    logic tcnt_inc;
    logic bit_clr;
    logic shift_en;
    logic push_byte;
    logic set_fe;

    always_comb begin
        tick_restart = 1'b0;
        tcnt_clr     = 1'b0;
        tcnt_inc     = 1'b0;
        bit_clr      = 1'b0;
        shift_en     = 1'b0;
        push_byte    = 1'b0;
        set_fe       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    tick_restart = 1'b1;
                    tcnt_clr     = 1'b1;
                end
            end
            START: begin
                if (mid_tick) begin
                    tcnt_clr = 1'b1;
                    bit_clr  = 1'b1;
                end else if (tick) begin
                    tcnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    tcnt_clr = 1'b1;
                    shift_en = 1'b1;
                end else if (tick) begin
                    tcnt_inc = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    tcnt_clr  = 1'b1;
                    push_byte = rx_sync_q;
                    set_fe    = !rx_sync_q;
                end else if (tick) begin
                    tcnt_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            if (tcnt_clr)      tick_cnt_q <= '0;
            else if (tcnt_inc) tick_cnt_q <= tick_cnt_q + 1'b1;

            if (bit_clr)       bit_cnt_q <= '0;
            else if (shift_en) bit_cnt_q <= bit_cnt_q + 1'b1;

            // LSB arrives first, so shift in from the top.
            if (shift_en) shift_q <= {rx_sync_q, shift_q[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Bus decode and FIFO
    // ------------------------------------------------------------------
    logic [11:0]   addr_lo;
    logic          acc;
    logic          rd_acc;
    logic          wr_acc;
    logic          is_status;
    logic          is_rxdata;
    logic          rd_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          ovr_set;
    logic          overrun_q;
    logic          frame_err_q;
    logic          unused_bus;

    assign addr_lo   = bus.addr[11:0];
    assign acc       = bus.sel && bus.enable;
    assign rd_acc    = acc && !bus.write;
    assign wr_acc    = acc && bus.write;
    assign is_status = (addr_lo == A_STATUS);
    assign is_rxdata = (addr_lo == A_RXDATA);
    assign rd_pop    = rd_acc && is_rxdata && !fifo_empty;

    // Only a same-cycle pop makes room in a full FIFO.
    assign ovr_set   = push_byte && fifo_full && !rd_pop;

    assign unused_bus = ^{bus.addr[XLEN-1:12], bus.wdata[XLEN-1:4], bus.wdata[1:0]};

    riscv_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_byte),
        .data_i  (shift_q),
        .pop_i   (rd_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sticky error flags: W1C, a new event in the clearing cycle wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (ovr_set)
                overrun_q <= 1'b1;
            else if (wr_acc && is_status && bus.wdata[ST_OVERRUN])
                overrun_q <= 1'b0;

            if (set_fe)
                frame_err_q <= 1'b1;
            else if (wr_acc && is_status && bus.wdata[ST_FRAME_ERR])
                frame_err_q <= 1'b0;
        end
    end

    logic [15:0]     status_w;
    logic [XLEN-1:0] rd_mux;

    always_comb begin
        status_w                     = '0;
        status_w[ST_NONEMPTY]        = !fifo_empty;
        status_w[ST_FULL]            = fifo_full;
        status_w[ST_OVERRUN]         = overrun_q;
        status_w[ST_FRAME_ERR]       = frame_err_q;
        status_w[ST_COUNT_LSB +: 8]  = 8'(fifo_count);
    end

    always_comb begin
        rd_mux = '0;
        if (bus.sel && !bus.write) begin
            case (addr_lo)
                A_STATUS: rd_mux = XLEN'(status_w);
                A_RXDATA: if (!fifo_empty) rd_mux = XLEN'(fifo_dout);
                default:  rd_mux = '0;
            endcase
        end
    end

    assign bus.rdata = rd_mux;

endmodule

// File: tb/tb_riscv_uart_rx.sv
// Purpose: directed self-checking bench for riscv_uart_rx at 16 clk per bit.
// Latency: frames are driven cycle-exactly so a read can be placed on the push cycle.
// Backpressure: exercised through FIFO full / overrun and same-cycle push/pop.
module tb_riscv_uart_rx;

    logic clk;
    logic rstn;
    logic rxd;
    int   n_tests;
    int   n_fail;
    logic [31:0] rd;
    logic [31:0] popped;

    riscv_uart_rx_if #(.XLEN(32)) bus_if ();

    riscv_uart_rx #(
        .XLEN       (32),
        .CLK_FREQ   (1_843_200),
        .BAUD       (115200),
        .FIFO_DEPTH (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if),
        .rxd  (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus_if.sel = 1'b1; bus_if.enable = 1'b0; bus_if.write = 1'b0; bus_if.addr = a;
        @(posedge clk); #1;
        bus_if.enable = 1'b1;
        @(negedge clk);
        d = bus_if.rdata;
        @(posedge clk); #1;
        bus_if.sel = 1'b0; bus_if.enable = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus_if.sel = 1'b1; bus_if.enable = 1'b0; bus_if.write = 1'b1;
        bus_if.addr = a; bus_if.wdata = d;
        @(posedge clk); #1;
        bus_if.enable = 1'b1;
        @(posedge clk); #1;
        bus_if.sel = 1'b0; bus_if.enable = 1'b0; bus_if.write = 1'b0;
    endtask

    // One 8N1 frame, 16 clocks per bit. With pop set, an RXDATA access is
    // placed in the cycle whose closing edge performs the mid-stop sample:
    // start edge seen after 3 clk, start checked 8 ticks later, then 9 more bits.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop,
                              output logic [31:0] got);
        got = '0;
        for (int j = 0; j < 160; j++) begin
            @(posedge clk); #1;
            if (j < 16)       rxd = 1'b0;
            else if (j < 144) rxd = b[(j - 16) / 16];
            else              rxd = stop;
            if (pop && j == 154) begin
                bus_if.sel = 1'b1; bus_if.enable = 1'b1;
                bus_if.write = 1'b0; bus_if.addr = 32'h008;
                @(negedge clk);
                got = bus_if.rdata;
            end
            if (pop && j == 155) begin
                bus_if.sel = 1'b0; bus_if.enable = 1'b0;
            end
        end
        @(posedge clk); #1;
        rxd = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        rxd     = 1'b1;
        bus_if.sel = 1'b0; bus_if.enable = 1'b0; bus_if.write = 1'b0;
        bus_if.addr = '0; bus_if.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", bus_if.rdata, 32'h0);
        #1 rstn = 1'b1;
        idle(4);

        // Reset state
        bus_read(32'h000, rd); check("reset_status", rd, 32'h0);
        bus_read(32'h008, rd); check("empty_rxdata", rd, 32'h0);

        // 1: single byte
        send_frame(8'hA5, 1'b1, 1'b0, popped);
        idle(4);
        bus_read(32'h000, rd); check("t1_status", rd, 32'h0000_0101);
        bus_read(32'h004, rd); check("t1_unmapped", rd, 32'h0);
        bus_read(32'h008, rd); check("t1_data", rd, 32'h0000_00A5);
        bus_read(32'h000, rd); check("t1_status_after", rd, 32'h0);

        // 2: short glitch rejected at start-bit check
        @(posedge clk); #1; rxd = 1'b0;
        idle(6); #1; rxd = 1'b1;
        idle(200);
        bus_read(32'h000, rd); check("t2_glitch_status", rd, 32'h0);

        // 3: framing error, then W1C
        send_frame(8'h3C, 1'b0, 1'b0, popped);
        idle(10);
        bus_read(32'h000, rd); check("t3_frame_err", rd, 32'h0000_0008);
        bus_write(32'h000, 32'h8);
        bus_read(32'h000, rd); check("t3_cleared", rd, 32'h0);

        // 4: nine bytes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, popped);
            idle(2);
        end
        bus_read(32'h000, rd); check("t4_full_ovr", rd, 32'h0000_0807);
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h008, rd); check("t4_order", rd, 32'(i));
        end
        bus_read(32'h000, rd); check("t4_drained", rd, 32'h0000_0004);
        bus_write(32'h000, 32'h4);
        bus_read(32'h000, rd); check("t4_ovr_clear", rd, 32'h0);

        // 5: pop in the same cycle as a push into a full FIFO
        for (int i = 0; i < 8; i++) begin
            send_frame(8'(8'h10 + i), 1'b1, 1'b0, popped);
            idle(2);
        end
        bus_read(32'h000, rd); check("t5_full", rd, 32'h0000_0803);
        send_frame(8'h18, 1'b1, 1'b1, popped);
        check("t5_pop_head", popped, 32'h10);
        idle(2);
        bus_read(32'h000, rd); check("t5_count_kept", rd, 32'h0000_0803);
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h008, rd); check("t5_order", rd, 32'(8'h11 + i));
        end
        bus_read(32'h000, rd); check("t5_empty", rd, 32'h0);

        // 6: reset in the middle of 0xFF's data bits
        @(posedge clk); #1; rxd = 1'b0;
        idle(16); #1; rxd = 1'b1;
        idle(40); #1; rstn = 1'b0;
        idle(3); #1; rstn = 1'b1;
        idle(20);
        bus_read(32'h000, rd); check("t6_after_reset", rd, 32'h0);
        send_frame(8'h12, 1'b1, 1'b0, popped);
        idle(4);
        bus_read(32'h000, rd); check("t6_status", rd, 32'h0000_0101);
        bus_read(32'h008, rd); check("t6_data", rd, 32'h0000_0012);
        bus_read(32'h000, rd); check("t6_status_after", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
